img_stream_tx: RTL and testbench

//  Frame-buffered pixel-stream transmitter feeding the 3x3 padded windowers.
//  - Accepts raster-order pixels from a bursty producer (valid/ready).
//  - Re-emits each complete image as one unbroken run of IMG_SIZE*IMG_SIZE valid cycles.
//  - Meets the windower contract: once the first pixel of an image is valid, every

---
 rtl/img_stream_pkg.sv | 33 +++
 rtl/img_stream_tx_sdp_ram.sv | 32 +++
 rtl/img_stream_tx.sv | 188 ++++++++++++++++++
 tb/tb_img_stream_tx.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/img_stream_pkg.sv
// Shared definitions for the image stream transmitter.
// The localparams here are the default image geometry; img_stream_tx takes
// these as parameter defaults and can be specialised per instance.
// Contents:
//   IMG_SIZE_DEF, CH_IN_DEF, BW_DEF, MIN_GAP_DEF  default geometry / spacing
//   N_PIX, ADDR_W                                 default pixels per image and counter width
//   pixel_t                                       default packed pixel type
//   tx_state_t                                    read-side FSM states
//   addr_bits()                                   counter width for a given pixel count
package img_stream_pkg;

    localparam int IMG_SIZE_DEF = 32;
    localparam int CH_IN_DEF    = 3;
    localparam int BW_DEF       = 16;
    localparam int MIN_GAP_DEF  = 0;

    localparam int N_PIX  = IMG_SIZE_DEF * IMG_SIZE_DEF;
    localparam int ADDR_W = $clog2(N_PIX);

    typedef logic [CH_IN_DEF-1:0][BW_DEF-1:0] pixel_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        GAP    = 2'd2
    } tx_state_t;

    // Width of a counter addressing n pixels (at least one bit).
    function automatic int addr_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/img_stream_tx_sdp_ram.sv
// Simple dual-port RAM: one write port, one read port, registered read data.
// Data storage has no reset; contents are only meaningful once written.
// Ports:
//   clock  in   rising-edge clock
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write data
//   raddr  in   read address, data appears on rdata one cycle later
//   rdata  out  registered read data
module sdp_ram #(
    parameter int WIDTH = 48,
    parameter int DEPTH = 2048,
    parameter int AW    = 11
) (
    input  logic             clock,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/img_stream_tx.sv
// Frame-buffered pixel stream transmitter.
// Collects raster-order pixels from a bursty producer into one of two banks and,
// once a bank holds a complete image, replays it as an unbroken run of
// IMG_SIZE*IMG_SIZE valid cycles. While one bank streams out, the other fills.
//
// Handshake: a pixel moves on the input side in every cycle where
// vld_in && rdy_out at the rising clock edge. rdy_out depends on registers only,
// so the producer may hold vld_in/in steady until it sees rdy_out high. The
// output side has no ready: once sof_out is seen, vld_out stays high until and
// including the eof_out cycle.
//
// Ports:
//   clock      in   rising-edge clock
//   reset      in   synchronous, active-low
//   vld_in     in   producer pixel valid
//   rdy_out    out  transmitter can take a pixel this cycle
//   in         in   pixel [CH_IN-1:0][BW-1:0], raster order
//   vld_out    out  output pixel valid
//   out        out  output pixel, same packing as in
//   sof_out    out  first pixel of an image (with vld_out)
//   eof_out    out  last pixel of an image (with vld_out)
//   fsm_state  out  read-side FSM state, for observation
module img_stream_tx
    import img_stream_pkg::*;
#(
    parameter int IMG_SIZE = IMG_SIZE_DEF,
    parameter int CH_IN    = CH_IN_DEF,
    parameter int BW       = BW_DEF,
    parameter int MIN_GAP  = MIN_GAP_DEF
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     vld_in,
    output logic                     rdy_out,
    input  logic [CH_IN-1:0][BW-1:0] in,
    output logic                     vld_out,
    output logic [CH_IN-1:0][BW-1:0] out,
    output logic                     sof_out,
    output logic                     eof_out,
    output tx_state_t                fsm_state
);

    localparam int PIX_CNT = IMG_SIZE * IMG_SIZE;
    localparam int AW      = addr_bits(PIX_CNT);
    localparam int PW      = CH_IN * BW;
    localparam int GW      = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;

    localparam logic [AW-1:0] LAST_ADDR = AW'(PIX_CNT - 1);

    // Bank bookkeeping
    logic          wr_bank;
    logic          rd_bank;
    logic [1:0]    full;
    logic [1:0]    full_next;
    logic [AW-1:0] wr_addr;
    logic          accept;
    logic          wr_last;

    // Read FSM
    tx_state_t     state;
    tx_state_t     state_next;
    logic [AW-1:0] rd_addr;
    logic [AW-1:0] rd_addr_next;
    logic [GW-1:0] gap_cnt;
    logic [GW-1:0] gap_cnt_next;
    logic          rd_bank_next;
    logic          issue;
    logic          rd_done;

    logic [PW-1:0] ram_rdata;

    assign rdy_out   = !full[wr_bank];
    assign accept    = vld_in && rdy_out;
    assign wr_last   = (wr_addr == LAST_ADDR);
    assign fsm_state = state;
    assign out       = ram_rdata;

    sdp_ram #(
        .WIDTH (PW),
        .DEPTH (2 * PIX_CNT),
        .AW    (AW + 1)
    ) u_ram (
        .clock (clock),
        .we    (accept),
        .waddr ({wr_bank, wr_addr}),
        .wdata (in),
        .raddr ({rd_bank, rd_addr}),
        .rdata (ram_rdata)
    );

    // Set and clear never target the same bank: a bank is only written while
    // empty and only streamed while full, so both updates can apply together.
    always_comb begin
        full_next = full;
        if (rd_done) begin
            full_next[rd_bank] = 1'b0;
        end
        if (accept && wr_last) begin
            full_next[wr_bank] = 1'b1;
        end
    end

    always_comb begin
        state_next   = state;
        rd_addr_next = rd_addr;
        gap_cnt_next = gap_cnt;
        rd_bank_next = rd_bank;
        issue        = 1'b0;
        rd_done      = 1'b0;
        unique case (state)
            IDLE: begin
                if (full[rd_bank]) begin
                    state_next   = STREAM;
                    rd_addr_next = '0;
                end
            end
            STREAM: begin
                issue        = 1'b1;
                rd_addr_next = rd_addr + 1'b1;
                if (rd_addr == LAST_ADDR) begin
                    rd_done      = 1'b1;
                    rd_bank_next = ~rd_bank;
                    rd_addr_next = '0;
                    if (MIN_GAP > 0) begin
                        state_next   = GAP;
                        gap_cnt_next = GW'(MIN_GAP - 1);
                    end else if (full[~rd_bank]) begin
                        // Next image already complete: keep streaming with no bubble.
                        state_next = STREAM;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            GAP: begin
                if (gap_cnt == '0) begin
                    // Going straight to STREAM when the next bank is ready keeps
                    // the idle run between images at exactly MIN_GAP cycles.
                    if (full[rd_bank]) begin
                        state_next   = STREAM;
                        rd_addr_next = '0;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    gap_cnt_next = gap_cnt - 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state   <= IDLE;
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            full    <= 2'b00;
            wr_addr <= '0;
            rd_addr <= '0;
            gap_cnt <= '0;
            vld_out <= 1'b0;
            sof_out <= 1'b0;
            eof_out <= 1'b0;
        end else begin
            state   <= state_next;
            rd_addr <= rd_addr_next;
            rd_bank <= rd_bank_next;
            gap_cnt <= gap_cnt_next;
            full    <= full_next;
            if (accept) begin
                if (wr_last) begin
                    wr_addr <= '0;
                    wr_bank <= ~wr_bank;
                end else begin
                    wr_addr <= wr_addr + 1'b1;
                end
            end
            // Flags trail the read issue by one cycle to line up with RAM data.
            vld_out <= issue;
            sof_out <= issue && (rd_addr == '0);
            eof_out <= issue && (rd_addr == LAST_ADDR);
        end
    end

endmodule

// File: tb/tb_img_stream_tx.sv
// Self-checking bench for img_stream_tx with 4x4 single-channel 16-bit images.
// Main instance uses MIN_GAP=0; a second instance uses MIN_GAP=3.
// Reference model: accepted pixels collect into a frame; every complete frame
// is appended to the expected output queue, and its completion cycle is kept
// so the monitor can predict when the frame must start on the output.
module tb_img_stream_tx;
    import img_stream_pkg::*;

    localparam int NP = 16;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // ---------------- DUT (MIN_GAP = 0) ----------------
    logic        vld_in = 1'b0;
    logic        rdy_out;
    logic [15:0] pix_in = '0;
    logic        vld_out;
    logic [15:0] pix_out;
    logic        sof_out;
    logic        eof_out;
    tx_state_t   st0;

    img_stream_tx #(.IMG_SIZE(4), .CH_IN(1), .BW(16), .MIN_GAP(0)) dut (
        .clock     (clock),
        .reset     (reset),
        .vld_in    (vld_in),
        .rdy_out   (rdy_out),
        .in        (pix_in),
        .vld_out   (vld_out),
        .out       (pix_out),
        .sof_out   (sof_out),
        .eof_out   (eof_out),
        .fsm_state (st0)
    );

    // ---------------- DUT (MIN_GAP = 3) ----------------
    logic        g_vld = 1'b0;
    logic        g_rdy;
    logic [15:0] g_in = '0;
    logic        g_vld_out;
    logic [15:0] g_out;
    logic        g_sof;
    logic        g_eof;
    tx_state_t   st_g;

    img_stream_tx #(.IMG_SIZE(4), .CH_IN(1), .BW(16), .MIN_GAP(3)) dut_g (
        .clock     (clock),
        .reset     (reset),
        .vld_in    (g_vld),
        .rdy_out   (g_rdy),
        .in        (g_in),
        .vld_out   (g_vld_out),
        .out       (g_out),
        .sof_out   (g_sof),
        .eof_out   (g_eof),
        .fsm_state (st_g)
    );

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_fail   = 0;

    logic [17:0] exp_q[$];    // {sof, eof, data}
    logic [15:0] frame_q[$];  // pixels of the frame being collected
    int          done_q[$];   // completion cycle of each queued frame
    int          last_done = 0;
    int          last_eof  = -1000;
    bit          in_frame  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    task automatic clear_model();
        exp_q.delete();
        frame_q.delete();
        done_q.delete();
        last_eof = -1000;
        in_frame = 1'b0;
    endtask

    task automatic model_accept(input logic [15:0] v);
        frame_q.push_back(v);
        if (frame_q.size() == NP) begin
            for (int i = 0; i < NP; i++) begin
                exp_q.push_back({(i == 0), (i == NP - 1), frame_q[i]});
            end
            frame_q.delete();
            done_q.push_back(cyc);
            last_done = cyc;
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clock) begin
        logic [17:0] e;
        int d;
        int want;
        if (!reset) begin
            in_frame = 1'b0;
        end else if (vld_out) begin
            if (exp_q.size() == 0) begin
                check("unexpected_vld", 32'(vld_out), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("pix_data", 32'(pix_out), 32'(e[15:0]));
                check("pix_sof", 32'(sof_out), 32'(e[17]));
                check("pix_eof", 32'(eof_out), 32'(e[16]));
                if (e[17] && done_q.size() != 0) begin
                    d = done_q.pop_front();
                    // Follows the previous image directly if this one was complete
                    // before the reader issued the previous image's last pixel.
                    want = (d + 2 <= last_eof) ? last_eof + 1 : d + 3;
                    check("sof_cycle", 32'(cyc), 32'(want));
                end
                if (e[17]) in_frame = 1'b1;
                if (e[16]) begin
                    in_frame = 1'b0;
                    last_eof = cyc;
                end
            end
        end else if (in_frame) begin
            check("frame_contig", 32'(vld_out), 32'd1);
            in_frame = 1'b0;
        end
    end

    // ---------------- driver tasks (call at a negedge) ----------------
    task automatic send_pixel(input logic [15:0] v, output int acc, output int waited);
        vld_in = 1'b1;
        pix_in = v;
        waited = 0;
        acc    = -1;
        while (!rdy_out && waited < 100) begin
            @(negedge clock);
            waited++;
        end
        if (!rdy_out) begin
            check("accept_timeout", 32'(rdy_out), 32'd1);
            vld_in = 1'b0;
        end else begin
            acc = cyc;
            model_accept(v);
            @(negedge clock);
            vld_in = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clock);
    endtask

    task automatic apply_reset();
        @(negedge clock);
        reset  = 1'b0;
        vld_in = 1'b0;
        g_vld  = 1'b0;
        #1 clear_model();
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic wait_drain();
        for (int c = 0; c < 300; c++) begin
            if (exp_q.size() == 0 && !vld_out) break;
            @(negedge clock);
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    // ---------------- tests ----------------
    task automatic test_single_frame();
        int acc, w;
        apply_reset();
        for (int i = 0; i < NP; i++) begin
            send_pixel(16'(i), acc, w);
            idle($urandom_range(0, 3));
        end
        wait_drain();
    endtask

    task automatic test_three_frames();
        int acc, w;
        apply_reset();
        for (int i = 0; i < 3 * NP; i++) begin
            send_pixel(16'($urandom_range(0, 65535)), acc, w);
        end
        wait_drain();
    endtask

    task automatic test_backpressure();
        int acc, w, d0;
        logic first_rdy;
        apply_reset();
        for (int i = 0; i < 2 * NP; i++) begin
            send_pixel(16'($urandom_range(0, 65535)), acc, w);
            if (i == NP - 1) d0 = acc;
        end
        // Reader drains bank 0 over cycles d0+2..d0+17; both banks full in d0+17.
        first_rdy = rdy_out;
        check("bp_rdy_low", 32'(first_rdy), 32'd0);
        send_pixel(16'h00AA, acc, w);
        check("bp_accept_cycle", 32'(acc), 32'(d0 + 18));
        for (int i = 1; i < NP; i++) begin
            send_pixel(16'($urandom_range(0, 65535)), acc, w);
        end
        wait_drain();
    endtask

    task automatic test_same_cycle_flags();
        int acc, w, d0;
        apply_reset();
        for (int i = 0; i < NP; i++) begin
            send_pixel(16'(16'h0200 + i), acc, w);
        end
        d0 = acc;
        for (int i = 0; i < NP - 1; i++) begin
            send_pixel(16'(16'h0300 + i), acc, w);
        end
        while (cyc < d0 + 17) @(negedge clock);
        // Bank 1 completes in the cycle bank 0's last pixel is read out.
        send_pixel(16'h030F, acc, w);
        check("t6_done_cycle", 32'(acc), 32'(d0 + 17));
        check("t6_rdy_after", 32'(rdy_out), 32'd1);
        wait_drain();
    endtask

    task automatic test_reset_midstream();
        int acc, w;
        bit seen;
        apply_reset();
        for (int i = 0; i < NP; i++) begin
            send_pixel(16'(i), acc, w);
        end
        seen = 1'b0;
        for (int c = 0; c < 60 && !seen; c++) begin
            @(negedge clock);
            if (vld_out && pix_out == 16'd7) seen = 1'b1;
        end
        check("t5_pix7_seen", 32'(seen), 32'd1);
        #1;
        reset = 1'b0;
        clear_model();
        @(negedge clock);
        check("t5_vld_after_rst", 32'(vld_out), 32'd0);
        check("t5_sof_after_rst", 32'(sof_out), 32'd0);
        check("t5_rdy_after_rst", 32'(rdy_out), 32'd1);
        reset = 1'b1;
        @(negedge clock);
        for (int i = 0; i < NP; i++) begin
            send_pixel(16'(100 + i), acc, w);
            idle($urandom_range(0, 2));
        end
        wait_drain();
    endtask

    task automatic test_min_gap();
        logic [15:0] seen[$];
        int sof_c[$];
        int eof_c[$];
        int k;
        apply_reset();
        fork
            begin
                k = 0;
                g_vld = 1'b1;
                g_in = 16'd0;
                for (int c = 0; c < 200 && k < 2 * NP; c++) begin
                    if (g_rdy) k++;
                    @(negedge clock);
                    if (k < 2 * NP) g_in = 16'(k);
                    else g_vld = 1'b0;
                end
                g_vld = 1'b0;
            end
            begin
                for (int c = 0; c < 120; c++) begin
                    @(negedge clock);
                    if (g_vld_out) begin
                        seen.push_back(g_out);
                        if (g_sof) sof_c.push_back(cyc);
                        if (g_eof) eof_c.push_back(cyc);
                    end
                end
            end
        join
        check("g_count", 32'(seen.size()), 32'(2 * NP));
        for (int i = 0; i < seen.size() && i < 2 * NP; i++) begin
            check("g_data", 32'(seen[i]), 32'(i));
        end
        check("g_sof_count", 32'(sof_c.size()), 32'd2);
        check("g_eof_count", 32'(eof_c.size()), 32'd2);
        if (sof_c.size() >= 2 && eof_c.size() >= 2) begin
            check("g_gap_low_cycles", 32'(sof_c[1] - eof_c[0] - 1), 32'd3);
            check("g_frame1_span", 32'(eof_c[1] - sof_c[1]), 32'(NP - 1));
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        reset  = 1'b0;
        vld_in = 1'b0;
        g_vld  = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_vld_out", 32'(vld_out), 32'd0);
        check("rst_sof_out", 32'(sof_out), 32'd0);
        check("rst_eof_out", 32'(eof_out), 32'd0);
        check("rst_rdy_out", 32'(rdy_out), 32'd1);
        check("rst_state", 32'(st0), 32'(IDLE));
        check("rst_g_rdy_out", 32'(g_rdy), 32'd1);
        reset = 1'b1;
        @(negedge clock);

        test_single_frame();
        test_three_frames();
        test_backpressure();
        test_min_gap();
        test_same_cycle_flags();
        test_reset_midstream();

        idle(5);
        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
